voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_pkg.sv | 24 ++
 rtl/voice_allocator.sv | 174 +++++++++++++++++
 tb/tb_voice_allocator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared types and widths for the voice allocator: FSM state encoding and the
// per-voice record held in the allocator's register array.
package voice_allocator_pkg;

  localparam int PERIOD_W  = 23;
  localparam int VOL_W     = 7;
  localparam int NOTE_W    = 7;
  // Storage width of the age field; the allocator saturates at 2^AGE_W-1 (AGE_W <= 16).
  localparam int AGE_MAX_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t SCAN   = 2'd1;
  localparam state_t COMMIT = 2'd2;

  typedef struct packed {
    logic [PERIOD_W-1:0]  period;
    logic [VOL_W-1:0]     volume;
    logic [NOTE_W-1:0]    note;
    logic                 active;
    logic [AGE_MAX_W-1:0] age;
  } voice_t;

endpackage

// File: rtl/voice_allocator.sv
// Assigns note-on/note-off events to a bank of triangle-wave voices.
// Optional macro VOICE_STEAL_EN: when no voice is free, steal the oldest one instead of dropping.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_note_on,
  input  logic [NOTE_W-1:0]              ev_note,
  input  logic [VOL_W-1:0]               ev_velocity,
  input  logic [PERIOD_W-1:0]            ev_period,
  output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  output logic [NUM_VOICES*VOL_W-1:0]    voice_volume,
  output logic [NUM_VOICES-1:0]          voice_reset,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic                           ev_dropped
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_MAX_W-1:0] AGE_SAT = AGE_MAX_W'((1 << AGE_W) - 1);

  state_t state;
  voice_t voices [NUM_VOICES];
  logic [IDX_W-1:0] scan_idx;

  logic                lat_on;
  logic [NOTE_W-1:0]   lat_note;
  logic [VOL_W-1:0]    lat_vel;
  logic [PERIOD_W-1:0] lat_period;

  logic                  match_found;
  logic [IDX_W-1:0]      match_idx;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic [NUM_VOICES-1:0] off_mask;
`ifdef VOICE_STEAL_EN
  logic                 old_found;
  logic [IDX_W-1:0]     old_idx;
  logic [AGE_MAX_W-1:0] old_age;
`endif

  logic             have_target;
  logic [IDX_W-1:0] target_idx;
  logic             commit_on;

  // Target priority: retrigger an equal note, else first free voice, else (optionally) the oldest.
  always_comb begin
    have_target = 1'b0;
    target_idx  = '0;
    if (match_found) begin
      have_target = 1'b1;
      target_idx  = match_idx;
    end else if (free_found) begin
      have_target = 1'b1;
      target_idx  = free_idx;
    end
`ifdef VOICE_STEAL_EN
    else if (old_found) begin
      have_target = 1'b1;
      target_idx  = old_idx;
    end
`endif
  end

  assign commit_on = (state == COMMIT) && lat_on && have_target;
  assign ev_ready  = (state == IDLE);

`ifdef VOICE_STEAL_EN
  assign ev_dropped = 1'b0;
`else
  assign ev_dropped = (state == COMMIT) && lat_on && !have_target;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      scan_idx    <= '0;
      lat_on      <= 1'b0;
      lat_note    <= '0;
      lat_vel     <= '0;
      lat_period  <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      off_mask    <= '0;
`ifdef VOICE_STEAL_EN
      old_found   <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
`endif
      for (int i = 0; i < NUM_VOICES; i++) voices[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_valid) begin
            // A zero-velocity note-on is a note-off in MIDI running-status practice.
            lat_on      <= ev_note_on && (ev_velocity != '0);
            lat_note    <= ev_note;
            lat_vel     <= ev_velocity;
            lat_period  <= ev_period;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            off_mask    <= '0;
`ifdef VOICE_STEAL_EN
            old_found   <= 1'b0;
`endif
            scan_idx    <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (voices[scan_idx].active && voices[scan_idx].note == lat_note) begin
            off_mask[scan_idx] <= 1'b1;
            if (!match_found) begin
              match_found <= 1'b1;
              match_idx   <= scan_idx;
            end
          end
          if (!voices[scan_idx].active && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
`ifdef VOICE_STEAL_EN
          if (voices[scan_idx].active && (!old_found || voices[scan_idx].age > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= scan_idx;
            old_age   <= voices[scan_idx].age;
          end
`endif
          if (scan_idx == LAST_IDX) state <= COMMIT;
          else scan_idx <= scan_idx + 1'b1;
        end
        COMMIT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (lat_on) begin
              if (have_target) begin
                if (IDX_W'(i) == target_idx) begin
                  voices[i].period <= lat_period;
                  voices[i].volume <= lat_vel;
                  voices[i].note   <= lat_note;
                  voices[i].active <= 1'b1;
                  voices[i].age    <= '0;
                end else if (voices[i].active && voices[i].age < AGE_SAT) begin
                  voices[i].age <= voices[i].age + 1'b1;
                end
              end
            end else if (off_mask[i]) begin
              voices[i].active <= 1'b0;
              voices[i].volume <= '0;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Idle voices are held in reset; a (re)triggered voice gets a one-cycle restart pulse.
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_period[g*PERIOD_W +: PERIOD_W] = voices[g].period;
    assign voice_volume[g*VOL_W +: VOL_W]       = voices[g].volume;
    assign voice_active[g] = voices[g].active;
    assign voice_reset[g]  = !voices[g].active || (commit_on && target_idx == IDX_W'(g));
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized self-checking bench for voice_allocator against an array-based voice model.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int NV = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   ev_valid;
  logic                   ev_ready;
  logic                   ev_note_on;
  logic [NOTE_W-1:0]      ev_note;
  logic [VOL_W-1:0]       ev_velocity;
  logic [PERIOD_W-1:0]    ev_period;
  logic [NV*PERIOD_W-1:0] voice_period;
  logic [NV*VOL_W-1:0]    voice_volume;
  logic [NV-1:0]          voice_reset;
  logic [NV-1:0]          voice_active;
  logic                   ev_dropped;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_note_on(ev_note_on), .ev_note(ev_note), .ev_velocity(ev_velocity),
    .ev_period(ev_period), .voice_period(voice_period), .voice_volume(voice_volume),
    .voice_reset(voice_reset), .voice_active(voice_active), .ev_dropped(ev_dropped)
  );

  int compared   = 0;
  int mismatched = 0;

  int mPeriod [NV];
  int mVol    [NV];
  int mNote   [NV];
  int mAge    [NV];
  bit mActive [NV];

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NV; i++) begin
      mPeriod[i] = 0; mVol[i] = 0; mNote[i] = 0; mAge[i] = 0; mActive[i] = 0;
    end
  endfunction

  // Apply one event to the model; returns the retriggered/assigned voice (-1 if none).
  function automatic void modelEvent(input bit on, input int note, input int vel, input int period,
                                     output int target, output bit dropped);
    target  = -1;
    dropped = 0;
    if (on && vel != 0) begin
      for (int i = 0; i < NV; i++) if (target < 0 && mActive[i] && mNote[i] == note) target = i;
      for (int i = 0; i < NV; i++) if (target < 0 && !mActive[i]) target = i;
      if (target < 0) begin
`ifdef VOICE_STEAL_EN
        target = 0;
        for (int i = 1; i < NV; i++) if (mAge[i] > mAge[target]) target = i;
`else
        dropped = 1;
`endif
      end
      if (target >= 0) begin
        for (int i = 0; i < NV; i++)
          if (i != target && mActive[i]) mAge[i] = (mAge[i] + 1 > (1 << AW) - 1) ? (1 << AW) - 1 : mAge[i] + 1;
        mPeriod[target] = period; mVol[target] = vel; mNote[target] = note;
        mActive[target] = 1; mAge[target] = 0;
      end
    end else begin
      for (int i = 0; i < NV; i++)
        if (mActive[i] && mNote[i] == note) begin mActive[i] = 0; mVol[i] = 0; end
    end
  endfunction

  function automatic logic [127:0] expPeriods();
    logic [127:0] v = '0;
    for (int i = 0; i < NV; i++) v[i*PERIOD_W +: PERIOD_W] = PERIOD_W'(mPeriod[i]);
    return v;
  endfunction

  function automatic logic [127:0] expVolumes();
    logic [127:0] v = '0;
    for (int i = 0; i < NV; i++) v[i*VOL_W +: VOL_W] = VOL_W'(mVol[i]);
    return v;
  endfunction

  function automatic logic [127:0] expActive();
    logic [127:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = mActive[i];
    return v;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".ready"},  ev_ready, 1'b1);
    checkOutput({tag, ".period"}, voice_period, expPeriods());
    checkOutput({tag, ".volume"}, voice_volume, expVolumes());
    checkOutput({tag, ".active"}, voice_active, expActive());
    checkOutput({tag, ".vreset"}, voice_reset, ~expActive() & 128'((1 << NV) - 1));
    checkOutput({tag, ".dropped"}, ev_dropped, 1'b0);
  endtask

  // Called #1 after the accepting edge; follows the event through scan and commit.
  task automatic finishEvent(input bit on, input int note, input int vel, input int period);
    logic [127:0] oldActive, expPulse;
    int target;
    bit dropped;
    oldActive = expActive();
    modelEvent(on, note, vel, period, target, dropped);
    expPulse = ~oldActive & 128'((1 << NV) - 1);
    if (target >= 0) expPulse[target] = 1'b1;
    @(negedge clk);
    checkOutput("busyReady", ev_ready, 1'b0);
    repeat (NV) @(negedge clk);
    checkOutput("commitReady",  ev_ready, 1'b0);
    checkOutput("commitActive", voice_active, oldActive);
    checkOutput("commitVReset", voice_reset, expPulse);
    checkOutput("commitDrop",   ev_dropped, dropped);
    @(negedge clk);
    checkIdleOutputs("done");
  endtask

  task automatic applyStimulus(input bit on, input int note, input int vel, input int period);
    int waitCnt = 0;
    @(negedge clk);
    ev_valid = 1'b1; ev_note_on = on;
    ev_note = NOTE_W'(note); ev_velocity = VOL_W'(vel); ev_period = PERIOD_W'(period);
    while (!ev_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!ev_ready) begin
      checkOutput("readyTimeout", ev_ready, 1'b1);
      ev_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ev_valid = 1'b0;
    finishEvent(on, note, vel, period);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; ev_valid = 1'b0; ev_note_on = 1'b0;
    ev_note = '0; ev_velocity = '0; ev_period = '0;
    doReset();
    checkIdleOutputs("reset");

    // Single note lands in voice 0.
    applyStimulus(1, 69, 100, 113636);
    checkOutput("a4Voice0Period", voice_period[PERIOD_W-1:0], PERIOD_W'(113636));
    checkOutput("a4Voice0Vol", voice_volume[VOL_W-1:0], 7'd100);

    // Retrigger the same note with a new velocity.
    applyStimulus(1, 69, 40, 113636);
    checkOutput("retrigVol", voice_volume[VOL_W-1:0], 7'd40);
    checkOutput("retrigActive", voice_active, 4'b0001);

    // Zero-velocity note-on releases; unmatched note-off changes nothing.
    applyStimulus(1, 69, 0, 5);
    checkOutput("velZeroOff", voice_active, 4'b0000);
    applyStimulus(0, 72, 50, 7);

    // Fill all voices, then one more note: stolen or dropped depending on build.
    doReset();
    applyStimulus(1, 60, 90, 1000);
    applyStimulus(1, 62, 91, 2000);
    applyStimulus(1, 64, 92, 3000);
    applyStimulus(1, 65, 93, 4000);
    applyStimulus(1, 67, 94, 5000);

    // Event held valid while the allocator is busy must be accepted once ready returns.
    doReset();
    @(negedge clk);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd50; ev_velocity = 7'd10; ev_period = 23'd321;
    @(posedge clk);
    #1 ev_note = 7'd51; ev_velocity = 7'd20; ev_period = 23'd654;
    begin
      int t; bit d;
      modelEvent(1, 50, 10, 321, t, d);
    end
    repeat (NV + 2) @(negedge clk);
    checkIdleOutputs("holdFirst");
    @(posedge clk);
    #1 ev_valid = 1'b0;
    finishEvent(1, 51, 20, 654);

    // Reset in the middle of a scan commits nothing.
    @(negedge clk);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd80; ev_velocity = 7'd99; ev_period = 23'd777;
    @(posedge clk);
    #1 ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkIdleOutputs("midScanReset");
    @(negedge clk);
    checkOutput("postResetReady", ev_ready, 1'b1);

    // Randomized traffic over a small note range to exercise matches, steals and drops.
    for (int n = 0; n < 150; n++) begin
      bit on;
      int note, vel, period;
      on     = ($urandom % 3) != 0;
      note   = 60 + int'($urandom % 6);
      vel    = ($urandom % 5 == 0) ? 0 : 1 + int'($urandom % 127);
      period = int'($urandom % (1 << PERIOD_W));
      repeat ($urandom % 3) @(negedge clk);
      applyStimulus(on, note, vel, period);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
